// File: rtl/regfile_mp.sv
// Purpose : multi-port register file, 2 combinational reads, 2 writes (B wins), built-in clear sweep.
// Latency : reads are zero-cycle (optional same-cycle write forwarding); writes land on the rising edge.
// Backpress: no handshake; writes arriving while ClrBusy=1 are dropped, never queued.
// Ports   : clock/Reset (sync, active-high); A1/A2 -> RD1/RD2 read ports;
//           A3/WD3/RegWEn write port A; A4/WD4/RegWEn2 write port B;
//           ClrReq starts a sweep, ClrBusy high during it, ClrDone pulses once at the end.
module regfile_mp #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            Reset,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            RegWEn,
    input  logic [AW-1:0]   A4,
    input  logic [XLEN-1:0] WD4,
    input  logic            RegWEn2,
    input  logic            ClrReq,
    output logic            ClrBusy,
    output logic            ClrDone
);

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

    clr_state_t        clr_state_q;
    logic [AW-1:0]     clr_idx_q;
    logic              clr_busy_q;
    logic              clr_done_q;

    logic [XLEN-1:0]   regs_q [NREG];

    // One bit per encodable address: set only for real, writable registers
    // (nonzero and below NREG). Built from constants so no range compare is
    // needed on the address buses themselves.
    logic [2**AW-1:0]  addr_ok;

    for (genvar g = 0; g < 2**AW; g++) begin : g_addr_ok
        assign addr_ok[g] = (g != 0) && (g < NREG);
    end

    // ------------------------------------------------------------------
    // Clear sequencer: IDLE -> SWEEP (index 1..NREG-1) -> DONE -> IDLE.
    // Busy/done are registered alongside the state so they are glitch-free.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (Reset) begin
            clr_state_q <= CLR_IDLE;
            clr_idx_q   <= '0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            case (clr_state_q)
                CLR_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (ClrReq) begin
                        clr_state_q <= CLR_SWEEP;
                        clr_idx_q   <= AW'(1);
                        clr_busy_q  <= 1'b1;
                    end
                end
                CLR_SWEEP: begin
                    // Stop on the last register so the index never wraps.
                    if (clr_idx_q == AW'(NREG - 1)) begin
                        clr_state_q <= CLR_DONE;
                        clr_busy_q  <= 1'b0;
                        clr_done_q  <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + 1'b1;
                    end
                end
                CLR_DONE: begin
                    clr_state_q <= CLR_IDLE;
                    clr_done_q  <= 1'b0;
                end
                default: begin
                    clr_state_q <= CLR_IDLE;
                    clr_busy_q  <= 1'b0;
                    clr_done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ClrBusy = clr_busy_q;
    assign ClrDone = clr_done_q;

    // ------------------------------------------------------------------
    // Register storage. Priority: reset > sweep clear > port B > port A.
    // Register 0 is only ever written by reset, so it holds 0 permanently.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        for (int i = 0; i < NREG; i++) begin
            if (Reset) begin
                regs_q[i] <= '0;
            end else if (clr_busy_q) begin
                if (clr_idx_q == AW'(i)) begin
                    regs_q[i] <= '0;
                end
            end else if (RegWEn2 && addr_ok[A4] && (A4 == AW'(i))) begin
                regs_q[i] <= WD4;
            end else if (RegWEn && addr_ok[A3] && (A3 == AW'(i))) begin
                regs_q[i] <= WD3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports. A matching pending write is forwarded only
    // when it would actually commit this edge (sweep not running). Address
    // validity of the write is implied by the read address being valid.
    // ------------------------------------------------------------------
    logic [AW-1:0]   raddr [2];
    logic [XLEN-1:0] rdata [2];

    assign raddr[0] = A1;
    assign raddr[1] = A2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        always_comb begin
            rdata[p] = '0;
            if (addr_ok[raddr[p]]) begin
                rdata[p] = regs_q[raddr[p]];
                if (BYPASS && !clr_busy_q) begin
                    if (RegWEn && (A3 == raddr[p])) begin
                        rdata[p] = WD3;
                    end
                    if (RegWEn2 && (A4 == raddr[p])) begin
                        rdata[p] = WD4;
                    end
                end
            end
        end
    end

    assign RD1 = rdata[0];
    assign RD2 = rdata[1];

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the register data width in bits.
REQ-002 The block SHALL have parameter NREG, default 32, giving the register count; the legal range is 4..256.
REQ-003 The block SHALL have parameter BYPASS, default 1, where 1 enables write-to-read forwarding.
REQ-004 The block SHALL derive local AW = clog2(NREG) as the address width.
REQ-005 The block SHALL have these ports:
- clock  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- A1  in  AW  read address, port 1.
- A2  in  AW  read address, port 2.
- RD1  out  XLEN  read data, port 1.
- RD2  out  XLEN  read data, port 2.
- A3  in  AW  write address, port A.
- WD3  in  XLEN  write data, port A.
- RegWEn  in  1  write enable, port A.
- A4  in  AW  write address, port B.
- WD4  in  XLEN  write data, port B.
- RegWEn2  in  1  write enable, port B.
- ClrReq  in  1  request a full register clear sweep.
- ClrBusy  out  1  clear sweep in progress.
- ClrDone  out  1  one-cycle pulse when the sweep completes.

Function
REQ-006 RD1 and RD2 SHALL be combinational reads of the addressed register, with zero-cycle latency.
REQ-007 Register 0 SHALL read as 0 at all times.
REQ-008 Writes to address 0 SHALL be discarded.
REQ-009 Write port A SHALL write WD3 to register A3 on the rising edge when RegWEn=1, A3!=0 and ClrBusy=0.
REQ-010 Write port B SHALL write WD4 to register A4 under the same rule, using RegWEn2.
REQ-011 When both ports write the same address in one cycle, port B (WD4) SHALL win.
REQ-012 Under BYPASS=1, a read address equal to a nonzero address being written in that cycle SHALL return the pending write data, before the edge.
- Port B data takes priority over port A data.
- Forwarding applies only when ClrBusy=0.
REQ-013 Under BYPASS=0, reads SHALL return the stored value; new data becomes visible only after the write edge.
REQ-014 Addresses at or above NREG SHALL read as 0, and writes to them SHALL be discarded.
REQ-015 The clear sequencer SHALL have three states:
- IDLE: ClrReq=1 moves to SWEEP and sets index to 1.
- SWEEP: each cycle writes 0 to register[index]; the state moves to DONE after index NREG-1 is written, otherwise index increments.
- DONE: lasts one cycle, then returns to IDLE.
REQ-016 ClrBusy SHALL be 1 exactly while in SWEEP, i.e. for NREG-1 cycles per sweep.
REQ-017 ClrDone SHALL be 1 exactly while in DONE.
REQ-018 While ClrBusy=1, external writes on both ports SHALL be dropped, not queued, and reads SHALL continue to return stored values.
REQ-019 ClrReq SHALL be ignored in SWEEP and DONE.
REQ-020 A ClrReq held high through DONE SHALL start a new sweep on the first IDLE cycle.
REQ-021 The sweep index SHALL never wrap; a SWEEP state with index >= NREG is unreachable.

Reset
REQ-022 On Reset=1 at a rising edge, all registers SHALL become 0.
REQ-023 On Reset=1 at a rising edge, the FSM SHALL go to IDLE, the index to 0, ClrBusy to 0 and ClrDone to 0.
REQ-024 Reset SHALL dominate writes and the sweep in the same cycle, including a reset during SWEEP, which aborts the sweep without asserting ClrDone.
REQ-025 Immediately after reset, RD1 and RD2 SHALL read 0 for every address.

Verification
REQ-026 The bench SHALL cover write-enable off: Reset, then RegWEn=0, A3=5, WD3=8, one edge, A2=5 -> RD2=0.
REQ-027 The bench SHALL cover write and forwarding: RegWEn=1, A3=15, WD3=1984, A1=15 -> RD1=1984 before the edge under BYPASS=1, and after the edge under BYPASS=0.
REQ-028 The bench SHALL cover register 0: RegWEn=1, A3=0, WD3=32'hDEADBEEF, edge, A1=0 -> RD1=0.
REQ-029 The bench SHALL cover the port conflict: A3=A4=7, WD3=1, WD4=2, both enables=1, edge, A1=7 -> RD1=2.
REQ-030 The bench SHALL cover a full clear sweep: register 10=32'h55, then a 1-cycle ClrReq pulse.
- ClrBusy is high for exactly 31 cycles, then ClrDone pulses for 1 cycle.
- A RegWEn write of A3=12, WD3=9 during the sweep is dropped.
- After the sweep, registers 10 and 12 read 0.
REQ-031 The bench SHALL cover reset mid-sweep: Reset=1 on the 5th SWEEP cycle -> after the edge ClrBusy=0, ClrDone never pulses, all registers read 0, and the FSM accepts a new ClrReq on the next cycle.
